// File: rtl/j_addr_pkg.sv
// Shared types and default widths for the Jerry DSP address stepper.
package j_addr_pkg;

  localparam int unsigned DefAw = 23;
  localparam int unsigned DefSw = 3;
  localparam int unsigned DefCw = 16;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/j_addr_wrapcalc.sv
// Combinational next-address calculation: borrow-aware subtract with optional window correction.
module j_addr_wrapcalc
  import j_addr_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned SW = DefSw
) (
  input  logic [AW-1:0] addr,
  input  logic [SW-1:0] amt,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] top,
  input  logic          ring_en,
  output logic [AW-1:0] next,
  output logic          wrap,
  output logic          borrow
);

  logic [AW:0]   diff;
  logic [AW-1:0] win;
  logic [AW-1:0] fixed;
  logic          below;

  assign diff   = {1'b0, addr} - {{(AW + 1 - SW){1'b0}}, amt};
  assign borrow = diff[AW];

  // A borrow means the true difference is negative, hence below any base.
  assign below = borrow | (diff[AW-1:0] < base);
  assign win   = top - base + {{(AW - 1){1'b0}}, 1'b1};
  assign fixed = diff[AW-1:0] + win;

  always_comb begin
    next = diff[AW-1:0];
    wrap = borrow;
    if (ring_en) begin
      wrap = below;
      if (below) begin
        next = fixed;
      end
    end
  end

endmodule

// File: rtl/j_addr_stepper.sv
// Registered address stepper: decrements a byte address per accepted step, linear or circular,
// for a programmed number of steps.
module j_addr_stepper
  import j_addr_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned SW = DefSw,
  parameter int unsigned CW = DefCw
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [AW-1:0] ld_addr,
  input  logic [CW-1:0] ld_cnt,
  input  logic          ring_en,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] top,
  input  logic [SW-1:0] amt,
  input  logic          step_vld,
  output logic          step_rdy,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          uflow,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          uflow_q, uflow_d;
  logic          done_q, done_d;

  logic [AW-1:0] calc_next;
  logic          calc_wrap;
  logic          calc_borrow;
  logic          accept;

  j_addr_wrapcalc #(
    .AW(AW),
    .SW(SW)
  ) u_wrapcalc (
    .addr   (addr_q),
    .amt    (amt),
    .base   (base),
    .top    (top),
    .ring_en(ring_en),
    .next   (calc_next),
    .wrap   (calc_wrap),
    .borrow (calc_borrow)
  );

  // ld takes priority, so a colliding step is never acknowledged.
  assign step_rdy = (state_q == StRun) & ~ld;
  assign accept   = step_vld & step_rdy;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    uflow_d = uflow_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (ld) begin
      addr_d  = ld_addr;
      cnt_d   = ld_cnt;
      uflow_d = 1'b0;
      state_d = (ld_cnt != '0) ? StRun : StIdle;
    end else if (accept) begin
      addr_d = calc_next;
      cnt_d  = cnt_q - {{(CW - 1){1'b0}}, 1'b1};
      wrap_d = calc_wrap;
      if (calc_borrow && !ring_en) begin
        uflow_d = 1'b1;
      end
      if (cnt_q == {{(CW - 1){1'b0}}, 1'b1}) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      uflow_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      uflow_q <= uflow_d;
      done_q  <= done_d;
    end
  end

  assign addr  = addr_q;
  assign cnt   = cnt_q;
  assign wrap  = wrap_q;
  assign uflow = uflow_q;
  assign done  = done_q;

endmodule

// File: tb/tb_j_addr_stepper.sv
// Self-checking bench for j_addr_stepper: arithmetic reference model plus directed scenarios.
module tb_j_addr_stepper;

  localparam int unsigned AW = 23;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 16;
  localparam longint Span = longint'(1) << AW;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [CW-1:0] ld_cnt = '0;
  logic          ring_en = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] top = '0;
  logic [SW-1:0] amt = '0;
  logic          step_vld = 1'b0;
  logic          step_rdy;
  logic [AW-1:0] addr;
  logic [CW-1:0] cnt;
  logic          wrap;
  logic          uflow;
  logic          done;

  int n_checks = 0;
  int n_fail = 0;

  j_addr_stepper #(
    .AW(AW),
    .SW(SW),
    .CW(CW)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .ld      (ld),
    .ld_addr (ld_addr),
    .ld_cnt  (ld_cnt),
    .ring_en (ring_en),
    .base    (base),
    .top     (top),
    .amt     (amt),
    .step_vld(step_vld),
    .step_rdy(step_rdy),
    .addr    (addr),
    .cnt     (cnt),
    .wrap    (wrap),
    .uflow   (uflow),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  longint m_addr = 0, m_cnt = 0;
  bit     m_wrap = 0, m_uflow = 0, m_done = 0, m_valid = 0;

  always @(posedge sys_clk) begin
    longint a;
    m_wrap = 0;
    m_done = 0;
    if (reset) begin
      m_addr  = 0;
      m_cnt   = 0;
      m_uflow = 0;
      m_valid = 1;
    end else if (ld) begin
      m_addr  = longint'(ld_addr);
      m_cnt   = longint'(ld_cnt);
      m_uflow = 0;
    end else if (m_cnt != 0 && step_vld) begin
      a = m_addr - longint'(amt);
      if (ring_en) begin
        if (a < longint'(base)) begin
          a      = a + (longint'(top) - longint'(base) + 1);
          m_wrap = 1;
        end
      end else if (a < 0) begin
        a       = a + Span;
        m_wrap  = 1;
        m_uflow = 1;
      end
      m_addr = a;
      m_cnt  = m_cnt - 1;
      m_done = (m_cnt == 0);
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      chk("model.addr", 64'(addr), 64'(m_addr));
      chk("model.cnt", 64'(cnt), 64'(m_cnt));
      chk("model.wrap", 64'(wrap), 64'(m_wrap));
      chk("model.uflow", 64'(uflow), 64'(m_uflow));
      chk("model.done", 64'(done), 64'(m_done));
      chk("model.step_rdy", 64'(step_rdy), 64'(m_cnt != 0 && !ld));
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic [SW-1:0] s);
    ld      = 1'b1;
    ld_addr = a;
    ld_cnt  = c;
    amt     = s;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    // Reset then idle
    tick();
    tick();
    reset = 1'b0;
    chk("rst.addr", 64'(addr), 64'h0);
    chk("rst.cnt", 64'(cnt), 64'h0);
    chk("rst.step_rdy", 64'(step_rdy), 64'h0);
    chk("rst.uflow", 64'(uflow), 64'h0);
    step_vld = 1'b1;
    repeat (5) tick();
    chk("idle.addr", 64'(addr), 64'h0);
    chk("idle.cnt", 64'(cnt), 64'h0);
    step_vld = 1'b0;

    // Linear run
    load(23'h000010, 16'd3, 3'd4);
    step_vld = 1'b1;
    tick();
    chk("lin.addr1", 64'(addr), 64'h0C);
    chk("lin.cnt1", 64'(cnt), 64'd2);
    tick();
    chk("lin.addr2", 64'(addr), 64'h08);
    chk("lin.done_early", 64'(done), 64'h0);
    tick();
    chk("lin.addr3", 64'(addr), 64'h04);
    chk("lin.done", 64'(done), 64'h1);
    chk("lin.cnt3", 64'(cnt), 64'h0);
    chk("lin.rdy_after", 64'(step_rdy), 64'h0);
    tick();
    chk("lin.done_once", 64'(done), 64'h0);
    chk("lin.addr_hold", 64'(addr), 64'h04);
    step_vld = 1'b0;

    // Linear underflow
    load(23'h000002, 16'd1, 3'd5);
    step_vld = 1'b1;
    tick();
    step_vld = 1'b0;
    chk("uf.addr", 64'(addr), 64'h7FFFFD);
    chk("uf.wrap", 64'(wrap), 64'h1);
    chk("uf.uflow", 64'(uflow), 64'h1);
    tick();
    chk("uf.wrap_pulse", 64'(wrap), 64'h0);
    chk("uf.sticky", 64'(uflow), 64'h1);

    // Circular wrap
    ring_en = 1'b1;
    base    = 23'h100;
    top     = 23'h10F;
    load(23'h000102, 16'd2, 3'd4);
    chk("ring.uflow_clr", 64'(uflow), 64'h0);
    step_vld = 1'b1;
    tick();
    chk("ring.addr1", 64'(addr), 64'h10E);
    chk("ring.wrap1", 64'(wrap), 64'h1);
    tick();
    step_vld = 1'b0;
    chk("ring.addr2", 64'(addr), 64'h10A);
    chk("ring.wrap2", 64'(wrap), 64'h0);
    chk("ring.uflow", 64'(uflow), 64'h0);
    chk("ring.done", 64'(done), 64'h1);
    ring_en = 1'b0;

    // Load collision
    load(23'h000400, 16'd5, 3'd1);
    chk("col.cnt5", 64'(cnt), 64'd5);
    ld       = 1'b1;
    ld_addr  = 23'h200;
    ld_cnt   = 16'd1;
    step_vld = 1'b1;
    #1;
    chk("col.rdy_low", 64'(step_rdy), 64'h0);
    @(posedge sys_clk);
    #1;
    ld = 1'b0;
    amt = 3'd4;
    chk("col.addr", 64'(addr), 64'h200);
    chk("col.cnt", 64'(cnt), 64'd1);
    chk("col.no_done", 64'(done), 64'h0);
    tick();
    step_vld = 1'b0;
    chk("col.addr_step", 64'(addr), 64'h1FC);
    chk("col.done", 64'(done), 64'h1);

    // Zero amount and zero-count load
    load(23'h000050, 16'd2, 3'd0);
    step_vld = 1'b1;
    tick();
    step_vld = 1'b0;
    chk("zero.addr", 64'(addr), 64'h50);
    chk("zero.cnt", 64'(cnt), 64'd1);
    chk("zero.wrap", 64'(wrap), 64'h0);
    load(23'h000077, 16'd0, 3'd1);
    chk("ld0.addr", 64'(addr), 64'h77);
    chk("ld0.rdy", 64'(step_rdy), 64'h0);
    chk("ld0.no_done", 64'(done), 64'h0);

    // Mid-run reset
    load(23'h000300, 16'd4, 3'd2);
    step_vld = 1'b1;
    tick();
    tick();
    chk("mrst.pre_addr", 64'(addr), 64'h2FC);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    step_vld = 1'b0;
    chk("mrst.addr", 64'(addr), 64'h0);
    chk("mrst.cnt", 64'(cnt), 64'h0);
    chk("mrst.done", 64'(done), 64'h0);
    chk("mrst.rdy", 64'(step_rdy), 64'h0);
    tick();
    chk("mrst.done_after", 64'(done), 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/j_addr_stepper.md
Name: j_addr_stepper

Overview:
- Registered, parametrised successor to the combinational size subtractor in the Jerry DSP address path.
- Holds a byte address and decrements it by a per-step amount on each accepted step.
- Two modes:
  - Linear: wraps at zero and flags underflow.
  - Circular: stays inside a [base, top] window.
- A transfer counter stops stepping after a programmed number of steps. The block sits between DSP control registers and the sample/DMA address bus.

Parameters:
- AW, 23, address width in bits.
- SW, 3, step-amount width in bits; amount range 0..2^SW-1.
- CW, 16, transfer-counter width in bits.

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld  in  1  load pulse: latches ld_addr and ld_cnt, clears flags.
- ld_addr  in  AW  start address.
- ld_cnt  in  CW  number of steps to perform; 0 means none.
- ring_en  in  1  1 = circular mode, 0 = linear mode.
- base  in  AW  circular window low bound, inclusive.
- top  in  AW  circular window high bound, inclusive; requires base <= top.
- amt  in  SW  decrement amount for the current step.
- step_vld  in  1  step request.
- step_rdy  out  1  step can be accepted this cycle.
- addr  out  AW  current address, registered.
- cnt  out  CW  remaining steps, registered.
- wrap  out  1  one-cycle pulse: last accepted step wrapped (window or zero).
- uflow  out  1  sticky: a linear-mode step borrowed past zero.
- done  out  1  one-cycle pulse when cnt transitions 1 -> 0.

Behaviour:
- Reset (synchronous, active-high, sys_clk):
  - addr=0, cnt=0, wrap=0, uflow=0, done=0, state=IDLE.
  - Reset asserted mid-run aborts immediately; no done pulse.
- States:
  - IDLE: cnt==0, step_rdy=0.
  - RUN: cnt!=0.
  - IDLE->RUN on ld with ld_cnt!=0. ld with ld_cnt==0 stays in IDLE but still loads addr.
  - RUN->IDLE on the accepted step that takes cnt to 0, or on ld with ld_cnt==0.
- Handshake:
  - step_rdy = (state==RUN) & ~ld, combinational from state and ld only.
  - A step is accepted when step_vld & step_rdy.
  - step_vld while step_rdy=0 is ignored, not queued.
- Step arithmetic:
  - diff = {1'b0,addr} - {0,amt}, computed AW+1 bits wide. amt is zero-extended.
  - Linear: next addr = diff[AW-1:0] (mod 2^AW). If diff[AW] (borrow) is set: wrap=1, uflow<=1.
  - Circular: if addr - amt < base (compare in AW+1 bits, borrow-aware), next = addr - amt + (top - base + 1) and wrap=1. Otherwise next = addr - amt.
  - Circular mode never sets uflow.
  - Circular mode with amt > window size is undefined; the bench does not cover it.
  - amt==0: accepted, addr unchanged, cnt still decrements, wrap=0.
- Per accepted step:
  - addr <= next; cnt <= cnt-1.
  - Result is visible on addr one cycle after acceptance (latency 1).
  - Back-to-back steps on consecutive cycles are supported (throughput 1/clk).
- done pulses for 1 cycle, in the cycle after the step that makes cnt 0.
- wrap is a 1-cycle pulse aligned with the addr update. It is 0 in any cycle with no accepted step.
- Simultaneous ld and step_vld:
  - ld wins; the step is dropped (step_rdy=0 that cycle).
  - addr<=ld_addr, cnt<=ld_cnt, uflow<=0, wrap=0, done=0.
- ld during RUN restarts cleanly; the old count is discarded with no done pulse.
- ring_en, base and top are sampled only at step acceptance, so changing them between steps is legal.

Decomposition:
- Shared package j_addr_pkg holds:
  - state enum (IDLE, RUN);
  - default width constants (AW=23, SW=3, CW=16).
- One sub-module j_addr_wrapcalc: combinational AW+1-bit borrow subtract plus window-correction adder. Inputs addr, amt, base, top, ring_en; outputs next, wrap, borrow.
- The registers, counter and handshake stay in j_addr_stepper.

Test Plan:
- Reset then idle: reset high 2 cycles -> addr=0, cnt=0, step_rdy=0, uflow=0. Then step_vld=1 for 5 cycles -> no change.
- Linear run: ld_addr=0x000010, ld_cnt=3, amt=4, step_vld held high -> addr 0x0C, 0x08, 0x04 on consecutive cycles; done pulse once; step_rdy=0 afterwards; cnt=0.
- Linear underflow: ld_addr=0x000002, ld_cnt=1, amt=5 -> addr=0x7FFFFD, wrap pulse=1, uflow=1 sticky until the next ld.
- Circular wrap: base=0x100, top=0x10F, ring_en=1, ld_addr=0x102, ld_cnt=2, amt=4 -> addr 0x10E with wrap=1, then 0x10A with wrap=0; uflow stays 0.
- Load collision: in RUN with cnt=5, assert ld (ld_addr=0x200, ld_cnt=1) and step_vld in the same cycle -> addr=0x200, cnt=1, no decrement, no done. Next step -> addr=0x200-amt, done pulse.
- Mid-run reset: after 2 of 4 steps, assert reset one cycle -> all outputs 0, no done pulse, step_rdy=0.
